// File: rtl/irq_ctrl.sv
// irq_ctrl: level/edge interrupt controller with PEND/MASK/MODE/VEC bus registers (clk, reset, cs_/as_/rw/addr/wr_data bus in, rd_data/rdy_ bus out, irq_in sources, cpu_irq request)
module irq_ctrl #(
  parameter int IRQ_NUM = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs_,
  input  logic               as_,
  input  logic               rw,
  input  logic [1:0]         addr,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               rdy_,
  input  logic [IRQ_NUM-1:0] irq_in,
  output logic               cpu_irq
);
  localparam int PAD = 32 - IRQ_NUM;
  logic [IRQ_NUM-1:0] pend, mask, mode, prev, act, wd, w1c, pend_nxt;
  logic               access, wr, rd;
  logic [3:0]         idx;
  logic [31:0]        rd_mux;
  assign access = !cs_ && !as_;
  assign wr     = access && !rw;
  assign rd     = access && rw;
  assign wd     = wr_data[IRQ_NUM-1:0];
  assign act    = pend & ~mask;
  assign w1c    = (wr && addr == 2'd0) ? wd : '0;
  assign pend_nxt = (mode & ((irq_in & ~prev) | (pend & ~w1c))) | (~mode & irq_in);
  always_comb begin
    idx = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--)
      if (act[i]) idx = 4'(i);
  end
  always_comb
    rd_mux = addr == 2'd0 ? {{PAD{1'b0}}, pend} :
             addr == 2'd1 ? {{PAD{1'b0}}, mask} :
             addr == 2'd2 ? {{PAD{1'b0}}, mode} :
                            {|act, 27'd0, idx};
  always_ff @(posedge clk) begin
    if (reset) begin
      pend    <= '0;
      mask    <= '1;
      mode    <= '0;
      prev    <= '0;
      rd_data <= '0;
      rdy_    <= 1'b1;
      cpu_irq <= 1'b0;
    end else begin
      pend    <= pend_nxt;
      prev    <= irq_in;
      if (wr && addr == 2'd1) mask <= wd;
      if (wr && addr == 2'd2) mode <= wd;
      rd_data <= rd ? rd_mux : '0;
      rdy_    <= !access;
      cpu_irq <= |act;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic checked against a behavioural model
module tb_irq_ctrl;
  logic        clk = 0, reset = 1, cs_ = 1, as_ = 1, rw = 1;
  logic [1:0]  addr = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic        rdy_, cpu_irq;
  logic [7:0]  irq_in = 0;
  int          checks = 0, errors = 0;
  logic [7:0]  m_pend, m_mask, m_mode, m_prev;
  logic [31:0] m_rd;
  logic        m_rdy, m_irq;

  irq_ctrl #(.IRQ_NUM(8)) dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_in(irq_in), .cpu_irq(cpu_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic       acc;
    logic [7:0] a, np;
    int         lo;
    acc = !cs_ && !as_;
    a = m_pend & ~m_mask;
    lo = -1;
    for (int i = 0; i < 8; i++) if (a[i] && lo < 0) lo = i;
    if (reset) begin
      m_pend <= 0; m_mask <= 8'hFF; m_mode <= 0; m_prev <= 0;
      m_rd <= 0; m_rdy <= 1; m_irq <= 0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (!m_mode[i]) np[i] = irq_in[i];
        else if (irq_in[i] && !m_prev[i]) np[i] = 1'b1;
        else if (acc && !rw && addr == 0 && wr_data[i]) np[i] = 1'b0;
        else np[i] = m_pend[i];
      m_pend <= np;
      m_prev <= irq_in;
      if (acc && !rw && addr == 1) m_mask <= wr_data[7:0];
      if (acc && !rw && addr == 2) m_mode <= wr_data[7:0];
      if (acc && rw)
        case (addr)
          0: m_rd <= {24'd0, m_pend};
          1: m_rd <= {24'd0, m_mask};
          2: m_rd <= {24'd0, m_mode};
          default: m_rd <= (lo < 0) ? 32'd0 : (32'h8000_0000 | 32'(lo));
        endcase
      else m_rd <= 0;
      m_rdy <= !acc;
      m_irq <= |a;
    end
  end

  task automatic cyc(input logic c, input logic a, input logic r, input logic [1:0] ad,
                     input logic [31:0] wd, input logic [7:0] irq, input logic rst = 0);
    cs_ = c; as_ = a; rw = r; addr = ad; wr_data = wd; irq_in = irq; reset = rst;
    @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] ad, input logic [31:0] wd, input logic [7:0] irq);
    cyc(0, 0, 0, ad, wd, irq);
  endtask
  task automatic rdc(input logic [1:0] ad, input logic [7:0] irq);
    cyc(0, 0, 1, ad, 0, irq);
  endtask
  task automatic idle(input logic [7:0] irq);
    cyc(1, 1, 1, 0, 0, irq);
  endtask

  task automatic test_reset;
    repeat (3) cyc(1, 1, 1, 0, 0, 0, 1);
    checks++; if ({rdy_, rd_data, cpu_irq} !== {1'b1, 32'd0, 1'b0}) begin errors++;
      $display("FAIL reset_state: rdy_=%b rd=%h irq=%b want 1 0 0", rdy_, rd_data, cpu_irq); end
    rdc(1, 0);
    checks++; if (rdy_ !== 0) begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy_); end
    checks++; if (rd_data !== 32'hFF) begin errors++; $display("FAIL reset_mask: got %h want 000000ff", rd_data); end
    checks++; if (cpu_irq !== 0) begin errors++; $display("FAIL reset_irq: got %b want 0", cpu_irq); end
    idle(0);
    checks++; if ({rdy_, rd_data} !== {1'b1, 32'd0}) begin errors++;
      $display("FAIL idle_bus: rdy_=%b rd=%h want 1 0", rdy_, rd_data); end
  endtask

  task automatic test_level;
    wr(1, 32'hFFFF_FFFE, 0);
    idle(1);
    checks++; if (cpu_irq !== 0) begin errors++; $display("FAIL level_lat0: irq %b want 0", cpu_irq); end
    rdc(0, 1);
    checks++; if (rd_data !== 32'h1) begin errors++; $display("FAIL level_pend: got %h want 1", rd_data); end
    checks++; if (cpu_irq !== 1) begin errors++; $display("FAIL level_irq: got %b want 1", cpu_irq); end
    repeat (3) idle(1);
    idle(0);
    checks++; if (cpu_irq !== 1) begin errors++; $display("FAIL level_fall1: got %b want 1", cpu_irq); end
    rdc(0, 0);
    checks++; if ({rd_data, cpu_irq} !== {32'd0, 1'b0}) begin errors++;
      $display("FAIL level_fall2: rd=%h irq=%b want 0 0", rd_data, cpu_irq); end
  endtask

  task automatic test_edge;
    wr(2, 4, 0);
    wr(1, 0, 0);
    idle(4);
    idle(0);
    checks++; if (cpu_irq !== 1) begin errors++; $display("FAIL edge_irq: got %b want 1", cpu_irq); end
    rdc(0, 0);
    checks++; if (rd_data !== 32'h4) begin errors++; $display("FAIL edge_hold: got %h want 4", rd_data); end
    rdc(3, 0);
    checks++; if (rd_data !== 32'h8000_0002) begin errors++; $display("FAIL edge_vec: got %h want 80000002", rd_data); end
    wr(0, 4, 0);
    checks++; if (cpu_irq !== 1) begin errors++; $display("FAIL w1c_lat: got %b want 1", cpu_irq); end
    idle(0);
    checks++; if (cpu_irq !== 0) begin errors++; $display("FAIL w1c_irq: got %b want 0", cpu_irq); end
    rdc(0, 0);
    checks++; if (rd_data !== 0) begin errors++; $display("FAIL w1c_pend: got %h want 0", rd_data); end
  endtask

  task automatic test_priority;
    idle(8'h28);
    idle(8'h28);
    rdc(3, 8'h28);
    checks++; if ({rd_data, cpu_irq} !== {32'h8000_0003, 1'b1}) begin errors++;
      $display("FAIL prio_vec3: rd=%h irq=%b want 80000003 1", rd_data, cpu_irq); end
    wr(1, 8, 8'h28);
    rdc(3, 8'h28);
    checks++; if ({rd_data, cpu_irq} !== {32'h8000_0005, 1'b1}) begin errors++;
      $display("FAIL prio_vec5: rd=%h irq=%b want 80000005 1", rd_data, cpu_irq); end
    idle(8'h28);
    checks++; if (cpu_irq !== 1) begin errors++; $display("FAIL prio_irq: got %b want 1", cpu_irq); end
  endtask

  task automatic test_w1c_race;
    wr(2, 2, 0);
    wr(1, 0, 0);
    idle(0);
    wr(0, 2, 2);
    rdc(0, 2);
    checks++; if (rd_data !== 32'h2) begin errors++; $display("FAIL race_pend: got %h want 2", rd_data); end
    checks++; if (cpu_irq !== 1) begin errors++; $display("FAIL race_irq: got %b want 1", cpu_irq); end
    wr(0, 2, 0);
    idle(0);
  endtask

  task automatic test_reset_mid;
    wr(2, 0, 0);
    wr(1, 0, 8'hFF);
    rdc(0, 8'hFF);
    checks++; if (rd_data !== 32'hFF) begin errors++; $display("FAIL rst_pre: got %h want ff", rd_data); end
    cyc(0, 0, 0, 1, 32'h55, 8'hFF, 1);
    checks++; if ({rdy_, rd_data, cpu_irq} !== {1'b1, 32'd0, 1'b0}) begin errors++;
      $display("FAIL rst_mid: rdy_=%b rd=%h irq=%b want 1 0 0", rdy_, rd_data, cpu_irq); end
    rdc(0, 8'hFF);
    checks++; if ({rdy_, rd_data} !== {1'b0, 32'd0}) begin errors++;
      $display("FAIL rst_pend: rdy_=%b rd=%h want 0 0", rdy_, rd_data); end
    rdc(1, 8'hFF);
    checks++; if (rd_data !== 32'hFF) begin errors++; $display("FAIL rst_mask: got %h want ff", rd_data); end
    rdc(2, 8'hFF);
    checks++; if (rd_data !== 0) begin errors++; $display("FAIL rst_mode: got %h want 0", rd_data); end
    checks++; if (cpu_irq !== 0) begin errors++; $display("FAIL rst_irq: got %b want 0", cpu_irq); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0 ? 1 : 0), 1'($urandom),
          2'($urandom), $urandom, 8'($urandom), 1'($urandom_range(0, 60) == 0));
      checks++; if (rdy_ !== m_rdy) begin errors++; $display("FAIL rand_rdy[%0d]: got %b want %b", n, rdy_, m_rdy); end
      checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL rand_rd[%0d]: got %h want %h", n, rd_data, m_rd); end
      checks++; if (cpu_irq !== m_irq) begin errors++; $display("FAIL rand_irq[%0d]: got %b want %b", n, cpu_irq, m_irq); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_level;
    test_edge;
    test_priority;
    test_w1c_race;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter IRQ_NUM, default 8, number of interrupt source lines (legal 1..16).
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port cs_  input  1  chip select, active low.
REQ-006 The block SHALL have port as_  input  1  address strobe, active low.
REQ-007 The block SHALL have port rw  input  1  1 = read, 0 = write.
REQ-008 The block SHALL have port addr  input  2  register select.
REQ-009 The block SHALL have port wr_data  input  32  write data.
REQ-010 The block SHALL have port rd_data  output  32  registered read data.
REQ-011 The block SHALL have port rdy_  output  1  registered ready, active low.
REQ-012 The block SHALL have port irq_in  input  IRQ_NUM  interrupt sources (e.g. timer irq), same clock domain, bit i = source i.
REQ-013 The block SHALL have port cpu_irq  output  1  registered interrupt request to CPU, active high.

Function
REQ-014 Access SHALL mean cs_=0 and as_=0 sampled at a rising edge.
REQ-015 rdy_ SHALL be 0 in the cycle after every access, else 1; the latency is fixed at 1 and there are no wait states.
REQ-016 Register map SHALL be: addr 0 PEND (R, W1C), addr 1 MASK (R/W, 1 = masked), addr 2 MODE (R/W, 1 = edge, 0 = level), addr 3 VEC (R only).
REQ-017 A read SHALL load rd_data at the access edge: bits [IRQ_NUM-1:0] = register and upper bits 0. VEC SHALL return bit31 = valid and bits[3:0] = index.
REQ-018 In cycles with no read access, rd_data SHALL be 0. Writes to VEC SHALL be ignored, and wr_data bits at or above IRQ_NUM SHALL be ignored.
REQ-019 MASK and MODE writes SHALL take effect at the access edge.
REQ-020 A level-mode line SHALL have PEND[i] <= irq_in[i] at every edge. W1C SHALL have no effect on it; the source itself must be cleared.
REQ-021 An edge-mode line SHALL keep prev[i] <= irq_in[i] at every edge.
REQ-022 An edge-mode line SHALL set PEND[i] when irq_in[i]=1 and prev[i]=0. PEND[i] SHALL clear only on a PEND write with wr_data[i]=1.
REQ-023 If an edge set and a W1C clear of the same bit occur in the same cycle, set SHALL win.
REQ-024 When MODE[i] changes from 0 to 1, PEND[i] SHALL retain its value. When MODE[i] changes from 1 to 0, PEND[i] SHALL follow irq_in[i] from the next edge.
REQ-025 Active vector act = PEND & ~MASK SHALL be evaluated combinationally from current register values.
REQ-026 VEC valid SHALL be |act, and VEC index SHALL be the lowest set bit of act. When none is set, valid=0 and index=0.
REQ-027 cpu_irq SHALL be <= |act at every edge. Latency from irq_in rising before edge k SHALL be: PEND set at edge k, cpu_irq=1 after edge k+1.
REQ-028 Masking a pending line SHALL drop cpu_irq one edge after the MASK write edge, unless another unmasked line is pending.
REQ-029 A VEC read SHALL reflect register state before the access edge, i.e. updates made at the same edge SHALL not be visible.

Reset
REQ-030 While reset=1 at an edge, the block SHALL set PEND=0, MASK=all ones, MODE=0, prev=0, rd_data=0, rdy_=1 and cpu_irq=0.
REQ-031 Reset SHALL take priority over any concurrent access or irq_in activity. An access in the reset cycle SHALL produce no rdy_ and no register write.
REQ-032 After reset, all lines SHALL be masked, so cpu_irq stays 0 until MASK is written.

Verification
REQ-033 The bench SHALL cover this scenario: reset, then read addr 1 -> rdy_=0 one cycle later, rd_data=0x000000FF, cpu_irq=0.
REQ-034 The bench SHALL cover this scenario: MASK=0xFE, level mode, irq_in[0] high 5 cycles -> PEND[0]=1 from first edge, cpu_irq=1 one edge later. irq_in[0] low -> PEND[0]=0 and cpu_irq=0 two edges after the fall.
REQ-035 The bench SHALL cover this scenario: MODE=0x04, MASK=0x00, one-cycle pulse on irq_in[2] -> PEND=0x04 held, VEC read=0x80000002. Write PEND=0x04 -> PEND=0 and cpu_irq=0 one edge later.
REQ-036 The bench SHALL cover this scenario: irq_in[3] and irq_in[5] pending, MASK=0x00 -> VEC=0x80000003. Write MASK=0x08 -> VEC=0x80000005, cpu_irq stays 1.
REQ-037 The bench SHALL cover this scenario: edge mode line 1, rising edge coincident with W1C of bit 1 -> PEND[1]=1 after the edge.
REQ-038 The bench SHALL cover this scenario: reset asserted while PEND=0xFF and a write is in progress -> all registers at reset values next cycle and rdy_=1.
